rsa_run_controller: RTL

Run controller for the RSA engine. Accepts single-cycle start/stop command pulses from two sources: the GPIO command path (synchronised, edge-detected) and the SPI register path. It arbitrates between them and sequences the engine through a start/abort/done handshake. It also exposes busy, sticky status flags and a run-cycle count for software readback.

---
 rtl/rsa_ctrl_pkg.sv | 18 +
 rtl/rsa_run_watchdog.sv | 32 +++
 rtl/rsa_run_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA run controller and its watchdog.
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    ABORT  = 2'd3
  } run_state_t;

  localparam int ST_DONE    = 0;
  localparam int ST_ABORTED = 1;
  localparam int ST_TIMEOUT = 2;

  localparam logic SRC_GPIO = 1'b0;
  localparam logic SRC_SPI  = 1'b1;

endpackage

// File: rtl/rsa_run_watchdog.sv
// Loadable down-counter; expired is high during the last counted cycle.
// Instantiated by rsa_run_controller only when RSA_RUN_CTRL_WATCHDOG_EN is defined.
module rsa_run_watchdog #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  // A count of one means the cycle being sampled is the final allowed one.
  assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/rsa_run_controller.sv
// Arbitrates GPIO/SPI start/stop pulses and sequences the engine start/abort/done handshake.
// Optional watchdog: define RSA_RUN_CTRL_WATCHDOG_EN.
module rsa_run_controller
  import rsa_ctrl_pkg::*;
#(
  parameter int          CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 gpio_start_cmd,
  input  logic                 gpio_stop_cmd,
  input  logic                 spi_start_cmd,
  input  logic                 spi_stop_cmd,
  input  logic                 eng_idle,
  input  logic                 eng_done,
  output logic                 eng_start,
  output logic                 eng_abort,
  output logic                 busy,
  output logic [2:0]           status,
  output logic                 src,
  output logic [CNT_WIDTH-1:0] run_cycles
);

  run_state_t           state_reg;
  logic                 eng_start_reg;
  logic                 eng_abort_reg;
  logic                 busy_reg;
  logic [2:0]           status_reg;
  logic                 src_reg;
  logic [CNT_WIDTH-1:0] run_cycles_reg;
  logic                 wd_expired;
  logic                 any_start;
  logic                 any_stop;

  assign any_start = gpio_start_cmd | spi_start_cmd;
  assign any_stop  = gpio_stop_cmd | spi_stop_cmd;

`ifdef RSA_RUN_CTRL_WATCHDOG_EN
  rsa_run_watchdog #(
    .WIDTH(32)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (ena && state_reg == IDLE),
    .load      (ena && state_reg == LAUNCH),
    .en        (ena && state_reg == RUN),
    .load_value(TIMEOUT_CYCLES),
    .expired   (wd_expired)
  );
`else
  // Never expires; the parameter is still referenced so both builds share one interface.
  assign wd_expired = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      eng_start_reg  <= 1'b0;
      eng_abort_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      status_reg     <= '0;
      src_reg        <= SRC_GPIO;
      run_cycles_reg <= '0;
    end else if (!ena) begin
      eng_start_reg <= 1'b0;
      eng_abort_reg <= 1'b0;
    end else begin
      eng_start_reg <= 1'b0;
      eng_abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_start && eng_idle) begin
            state_reg      <= LAUNCH;
            busy_reg       <= 1'b1;
            eng_start_reg  <= 1'b1;
            status_reg     <= '0;
            run_cycles_reg <= '0;
            src_reg        <= spi_start_cmd ? SRC_SPI : SRC_GPIO;
          end
        end
        LAUNCH: state_reg <= RUN;
        RUN: begin
          if (run_cycles_reg != '1) run_cycles_reg <= run_cycles_reg + CNT_WIDTH'(1);
          // Done outranks stop, which outranks the watchdog.
          if (eng_done) begin
            status_reg[ST_DONE] <= 1'b1;
            state_reg           <= IDLE;
            busy_reg            <= 1'b0;
          end else if (any_stop || wd_expired) begin
            status_reg[ST_ABORTED] <= 1'b1;
            if (!any_stop) status_reg[ST_TIMEOUT] <= 1'b1;
            state_reg     <= ABORT;
            eng_abort_reg <= 1'b1;
          end
        end
        ABORT: begin
          if (eng_idle) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign eng_start  = eng_start_reg;
  assign eng_abort  = eng_abort_reg;
  assign busy       = busy_reg;
  assign status     = status_reg;
  assign src        = src_reg;
  assign run_cycles = run_cycles_reg;

endmodule
